// File: rtl/wpn_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : wpn_pkg                                                           |
// | Brief  : Shared weapon FSM state type, default timing and saturating add   |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package wpn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DRAW     = 3'd1,
        ST_FIRE     = 3'd2,
        ST_HOLD     = 3'd3,
        ST_COOLDOWN = 3'd4
    } wpn_state_t;

    localparam int unsigned c_DRAW_FRAMES     = 6;
    localparam int unsigned c_HOLD_FRAMES     = 4;
    localparam int unsigned c_COOLDOWN_FRAMES = 10;
    localparam int unsigned c_ANIM_STEP       = 2;
    localparam int unsigned c_ANIM_MAX        = 12;

    // Sum is formed one bit wider so a carry out can never wrap past the limit.
    function automatic logic [11:0] sat_add(input logic [11:0] a,
                                            input logic [11:0] b,
                                            input logic [11:0] lim);
        logic [12:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, lim})
            return lim;
        else
            return sum[11:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/edge_rise.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : edge_rise                                                         |
// | Brief  : Registered rising-edge detector with configurable history reset   |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module edge_rise #(
    parameter logic PREV_RST = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise
);

    logic r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= PREV_RST;
            rise   <= 1'b0;
        end else begin
            r_prev <= sig;
            rise   <= sig & ~r_prev;
        end
    end

endmodule
`default_nettype wire

// File: rtl/archer_wpn_ctl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : archer_wpn_ctl                                                    |
// | Brief  : Archer attack FSM: draw, one-clock fire strobe, hold, cooldown    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module archer_wpn_ctl
    import wpn_pkg::*;
#(
    parameter int unsigned DRAW_FRAMES     = c_DRAW_FRAMES,
    parameter int unsigned HOLD_FRAMES     = c_HOLD_FRAMES,
    parameter int unsigned COOLDOWN_FRAMES = c_COOLDOWN_FRAMES,
    parameter int unsigned ANIM_STEP       = c_ANIM_STEP,
    parameter int unsigned ANIM_MAX        = c_ANIM_MAX
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mouse_left,
    input  logic        vsync,
    input  logic [1:0]  game_active,
    output logic        wpn_visible,
    output logic [11:0] anim_x_offset,
    output logic        attack_pulse,
    output logic        busy
);

    localparam logic [4:0]  c_DRAW_N = 5'(DRAW_FRAMES);
    localparam logic [4:0]  c_HOLD_N = 5'(HOLD_FRAMES);
    localparam logic [4:0]  c_COOL_N = 5'(COOLDOWN_FRAMES);
    localparam logic [11:0] c_STEP   = 12'(ANIM_STEP);
    localparam logic [11:0] c_MAX    = 12'(ANIM_MAX);

    logic       w_click;
    logic       w_tick;
    logic [4:0] w_cnt_inc;

    wpn_state_t r_state;
    logic [4:0] r_frame_cnt;

    // Mouse history resets high so a button held through reset cannot fire.
    edge_rise #(.PREV_RST(1'b1)) u_mouse_edge (
        .clk  (clk),
        .rst  (rst),
        .sig  (mouse_left),
        .rise (w_click)
    );

    edge_rise #(.PREV_RST(1'b0)) u_vsync_edge (
        .clk  (clk),
        .rst  (rst),
        .sig  (vsync),
        .rise (w_tick)
    );

    assign w_cnt_inc = r_frame_cnt + 5'd1;

    always_ff @(posedge clk) begin
        if (rst || (game_active == 2'b00)) begin
            r_state       <= ST_IDLE;
            r_frame_cnt   <= 5'd0;
            wpn_visible   <= 1'b0;
            anim_x_offset <= 12'd0;
            attack_pulse  <= 1'b0;
            busy          <= 1'b0;
        end else begin
            attack_pulse <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_click) begin
                        r_state       <= ST_DRAW;
                        r_frame_cnt   <= 5'd0;
                        wpn_visible   <= 1'b1;
                        anim_x_offset <= 12'd0;
                        busy          <= 1'b1;
                    end
                end
                ST_DRAW: begin
                    if (w_tick) begin
                        anim_x_offset <= sat_add(anim_x_offset, c_STEP, c_MAX);
                        if (w_cnt_inc == c_DRAW_N) begin
                            r_state     <= ST_FIRE;
                            r_frame_cnt <= 5'd0;
                        end else begin
                            r_frame_cnt <= w_cnt_inc;
                        end
                    end
                end
                // Strobe is registered on leaving FIRE so an abort during FIRE suppresses it.
                ST_FIRE: begin
                    r_state      <= ST_HOLD;
                    r_frame_cnt  <= 5'd0;
                    attack_pulse <= 1'b1;
                end
                ST_HOLD: begin
                    if (w_tick) begin
                        if (w_cnt_inc == c_HOLD_N) begin
                            r_state       <= ST_COOLDOWN;
                            r_frame_cnt   <= 5'd0;
                            wpn_visible   <= 1'b0;
                            anim_x_offset <= 12'd0;
                        end else begin
                            r_frame_cnt <= w_cnt_inc;
                        end
                    end
                end
                ST_COOLDOWN: begin
                    if (w_tick) begin
                        if (w_cnt_inc == c_COOL_N) begin
                            r_state     <= ST_IDLE;
                            r_frame_cnt <= 5'd0;
                            busy        <= 1'b0;
                        end else begin
                            r_frame_cnt <= w_cnt_inc;
                        end
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_frame_cnt   <= 5'd0;
                    wpn_visible   <= 1'b0;
                    anim_x_offset <= 12'd0;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/archer_wpn_ctl.md
# archer_wpn_ctl

Attack controller that drives the archer weapon sprite overlay. Turns a raw left-mouse level into one bounded attack cycle: draw-back animation, a single-clock fire strobe, hold, then cooldown. Frames are counted on the VGA vsync. Its outputs `wpn_visible` and `anim_x_offset` feed the `mouse_clicked` and `anim_x_offset` inputs of the weapon draw stage. `attack_pulse` feeds projectile/damage logic.

## Interface
Parameters:
- `DRAW_FRAMES`, 6, frames spent in the draw-back phase (1..31)
- `HOLD_FRAMES`, 4, frames the drawn bow stays at full extension (1..31)
- `COOLDOWN_FRAMES`, 10, frames with weapon hidden before the next attack is accepted (1..31)
- `ANIM_STEP`, 2, pixels added to the offset per draw frame
- `ANIM_MAX`, 12, offset saturation value

Ports:
- `clk`  in  1  pixel clock; the only clock
- `rst`  in  1  synchronous, active-high reset
- `mouse_left`  in  1  raw left-button level, already synchronous to `clk`
- `vsync`  in  1  VGA vsync level; a rising edge is one frame tick
- `game_active`  in  2  nonzero means gameplay is running
- `wpn_visible`  out  1  weapon sprite enable, registered
- `anim_x_offset`  out  12  horizontal sprite offset, registered, unsigned
- `attack_pulse`  out  1  one-clock fire strobe, registered
- `busy`  out  1  high in every state except IDLE

## Operation
- **Edge detection:** `click_edge = mouse_left & ~mouse_prev`; `tick = vsync & ~vsync_prev`.
  - `mouse_prev` resets to 1, so a button held through reset must be released before it can trigger an attack.
  - `vsync_prev` resets to 0.
- **States:** IDLE, DRAW, FIRE, HOLD, COOLDOWN. A 5-bit `frame_cnt` is cleared on every state entry.
- **IDLE:** `wpn_visible`=0, offset=0. On `click_edge && game_active!=0`, go to DRAW.
- **DRAW:** `wpn_visible`=1.
  - Each tick: offset = min(offset+ANIM_STEP, ANIM_MAX), and `frame_cnt` increments.
  - The tick that takes `frame_cnt` to DRAW_FRAMES goes to FIRE.
- **FIRE:** lasts exactly one clock. `attack_pulse`=1, offset held. Always goes to HOLD.
- **HOLD:** `wpn_visible`=1, offset held. After HOLD_FRAMES ticks, go to COOLDOWN.
- **COOLDOWN:** `wpn_visible`=0, offset=0. After COOLDOWN_FRAMES ticks, go to IDLE.
- **Clicks outside IDLE:** ignored, never queued. A click edge in the same clock as the COOLDOWN→IDLE transition is also ignored.
- **`game_active` becomes 0:** from any state, on the next clock go to IDLE with all outputs cleared. A FIRE in progress is aborted and its pulse is not issued.
- **Tick during FIRE:** not counted.
- **Offset arithmetic:** 12-bit unsigned, saturating at ANIM_MAX, never wraps.
- **Frame counter:** 5 bits, compared with `==`, never wraps.

## Timing
- **Reset values:** state=IDLE, `wpn_visible`=0, `anim_x_offset`=0, `attack_pulse`=0, `busy`=0, `frame_cnt`=0.
- **Input sampling:** inputs are sampled at clock edge N. The resulting state and outputs are visible after edge N+1, i.e. one clock of latency.
- **Tick to offset:** a tick seen in DRAW updates `anim_x_offset` one clock later.
- **`attack_pulse`:**
  - high for exactly one clock per completed draw;
  - the clock after the DRAW_FRAMES-th draw tick is registered;
  - never asserted twice per attack.
- **Click to fire latency (defaults):** 6 frame ticks + 1 clock.
- **Click to next accepted click (defaults):** 6+4+10 = 20 frame ticks, plus FIRE's single clock.
- **`rst` mid-attack:** the next clock shows reset values. A button still held at that point does not retrigger an attack.

## Structure
- **Shared weapon package (`wpn_pkg`):**
  - the state enum `wpn_state_t`;
  - default frame and animation constants, which are also reused by the melee controller.
- **Sub-module:** `edge_rise`, a registered rising-edge detector with a parameterised reset value of the previous sample. It is instantiated twice, once for mouse and once for vsync.
- **This module:** one registered FSM plus a datapath register block. No memories.

## Test plan
- **Reset behaviour:**
  - Stimulus: hold `rst` 3 clocks with `mouse_left`=1, then release, then keep the button held.
  - Required: all outputs 0, state stays IDLE.
  - Stimulus: release then press the button.
  - Required: DRAW entered one clock after the press, `wpn_visible`=1.
- **Full attack with defaults:**
  - Stimulus: a click, then 20 vsync pulses.
  - Required: offset steps 2,4,…,12.
  - Required: `attack_pulse` is high for exactly 1 clock, right after tick 6.
  - Required: `wpn_visible` falls after tick 10. `busy` falls after tick 20.
- **Saturation:**
  - Stimulus: ANIM_STEP=5, ANIM_MAX=12, DRAW_FRAMES=4.
  - Required: offset sequence 5, 10, 12, 12; never exceeds 12.
- **Ignored clicks:**
  - Stimulus: click during DRAW, HOLD, COOLDOWN, and on the COOLDOWN→IDLE clock.
  - Required: exactly one `attack_pulse` total. State returns to IDLE and stays there.
- **Abort:**
  - Stimulus: `game_active` drops to 0 at draw tick 3; separately, also on the FIRE clock.
  - Required: next clock shows IDLE, offset 0, `wpn_visible` 0, and no `attack_pulse` is issued.
- **Gating:**
  - Stimulus: click with `game_active`=0.
  - Required: no state change.
  - Stimulus: `game_active`=2'b10, then click.
  - Required: attack starts.
